// File: rtl/jk_seq_pkg.sv
// Shared JK sequential-logic definitions: excitation encodings and the
// helper that turns a (current, next) bit pair into {J,K}.
package jk_seq_pkg;

  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  // Minimal excitation: never emits toggle, so a bit only moves when it must.
  function automatic logic [1:0] jk_excite(input logic cur, input logic nxt);
    return {~cur & nxt, cur & ~nxt};
  endfunction

endpackage

// File: rtl/jk_ff_cell.sv
// Single rising-edge JK flip-flop with asynchronous active-high clear.
module jk_ff_cell
  import jk_seq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  logic r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_q <= 1'b0;
    else begin
      case ({j, k})
        JK_SET:    r_q <= 1'b1;
        JK_RESET:  r_q <= 1'b0;
        JK_TOGGLE: r_q <= ~r_q;
        default:   r_q <= r_q;
      endcase
    end
  end

  assign q = r_q;

endmodule

// File: rtl/jk_sync_counter.sv
// Modulo-MODULUS up/down counter whose state lives in a bank of JK cells;
// the target count is computed in binary then converted to J/K excitation.
module jk_sync_counter
  import jk_seq_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
    $error("jk_sync_counter: MODULUS must be in 2..2**WIDTH");
  end

  // WIDTH-bit top value keeps MODULUS == 2**WIDTH from overflowing.
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] w_q, w_nxt, w_j, w_k;
  logic             w_wrap_nxt, w_lerr_nxt;
  logic             r_wrap, r_lerr;

  always_comb begin
    w_nxt      = w_q;
    w_wrap_nxt = 1'b0;
    w_lerr_nxt = 1'b0;
    if (load) begin
      if (din > MAX) begin
        w_nxt      = '0;
        w_lerr_nxt = 1'b1;
      end else begin
        w_nxt = din;
      end
    end else if (en) begin
      if (up) begin
        if (w_q == MAX) begin
          w_nxt      = '0;
          w_wrap_nxt = 1'b1;
        end else if (w_q > MAX) begin
          w_nxt = '0;
        end else begin
          w_nxt = w_q + WIDTH'(1);
        end
      end else begin
        if (w_q == '0) begin
          w_nxt      = MAX;
          w_wrap_nxt = 1'b1;
        end else if (w_q > MAX) begin
          w_nxt = MAX;
        end else begin
          w_nxt = w_q - WIDTH'(1);
        end
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign {w_j[i], w_k[i]} = jk_excite(w_q[i], w_nxt[i]);
    jk_ff_cell u_cell (
      .clk (clk),
      .rst (rst),
      .j   (w_j[i]),
      .k   (w_k[i]),
      .q   (w_q[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrap <= 1'b0;
      r_lerr <= 1'b0;
    end else begin
      r_wrap <= w_wrap_nxt;
      r_lerr <= w_lerr_nxt;
    end
  end

  assign q        = w_q;
  assign tc       = en & (up ? (w_q == MAX) : (w_q == '0));
  assign wrap     = r_wrap;
  assign load_err = r_lerr;

endmodule

// File: tb/tb_jk_sync_counter.sv
// Directed bench for jk_sync_counter: reset, table of single-cycle vectors,
// and a two-stage decade cascade.
module tb_jk_sync_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, up, load;
  logic [3:0] din;
  logic [3:0] q;
  logic       tc, wrap, load_err;

  logic       c_en;
  logic [3:0] lo_q, hi_q;
  logic       lo_tc, hi_tc, lo_wrap, hi_wrap, lo_le, hi_le;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jk_sync_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din),
    .q(q), .tc(tc), .wrap(wrap), .load_err(load_err)
  );

  jk_sync_counter #(.WIDTH(4), .MODULUS(10)) u_lo (
    .clk(clk), .rst(rst), .en(c_en), .up(1'b1), .load(1'b0), .din(4'd0),
    .q(lo_q), .tc(lo_tc), .wrap(lo_wrap), .load_err(lo_le)
  );

  jk_sync_counter #(.WIDTH(4), .MODULUS(10)) u_hi (
    .clk(clk), .rst(rst), .en(lo_tc), .up(1'b1), .load(1'b0), .din(4'd0),
    .q(hi_q), .tc(hi_tc), .wrap(hi_wrap), .load_err(hi_le)
  );

  typedef struct {
    logic       ld, en, up;
    logic [3:0] din;
    logic       tc;   // expected before the edge
    logic [3:0] q;    // expected after the edge
    logic       wr, le;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic l, input logic e, input logic u, input int d,
                     input logic t, input int eq, input logic w, input logic le);
    vec_t v;
    v.ld = l; v.en = e; v.up = u; v.din = 4'(d);
    v.tc = t; v.q = 4'(eq); v.wr = w; v.le = le;
    vecs.push_back(v);
  endtask

  initial begin
    int m_lo, m_hi;
    rst = 1'b1; en = 0; up = 0; load = 0; din = 0; c_en = 0;

    // Up-wrap from 0
    for (int i = 0; i < 10; i++) add(0, 1, 1, 0, i == 9, (i + 1) % 10, i == 9, 0);
    // Down-wrap after load 2
    add(1, 0, 0, 2, 0, 2, 0, 0);
    add(0, 1, 0, 0, 0, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1, 9, 1, 0);
    add(0, 1, 0, 0, 0, 8, 0, 0);
    // Load beats enable; bad loads clear and flag
    add(1, 1, 1, 5, 0, 5, 0, 0);
    add(1, 0, 1, 12, 0, 0, 0, 1);
    add(0, 0, 1, 0, 0, 0, 0, 0);
    add(1, 0, 1, 9, 0, 9, 0, 0);
    add(0, 0, 1, 0, 0, 9, 0, 0);
    add(0, 1, 1, 0, 1, 0, 1, 0);
    add(1, 1, 0, 10, 1, 0, 0, 1);
    add(1, 0, 0, 15, 0, 0, 0, 1);
    // Hold at 6
    add(1, 0, 0, 6, 0, 6, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 0, i[0], 0, 0, 6, 0, 0);

    // Reset behaviour
    repeat (2) @(negedge clk);
    chk("rst_q", q, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_lerr", load_err, 0);
    rst = 0; en = 1; up = 1;
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("pre_async_q", q, 7);
    #2 rst = 1;
    #1;
    chk("async_rst_q", q, 0);
    chk("async_rst_lerr", load_err, 0);
    @(negedge clk);
    rst = 0; en = 1; up = 1;
    @(posedge clk); #1;
    chk("first_count_q", q, 1);
    @(negedge clk);
    rst = 1; en = 0;
    #1 rst = 0;

    // Vector table
    foreach (vecs[i]) begin
      load = vecs[i].ld; en = vecs[i].en; up = vecs[i].up; din = vecs[i].din;
      #1;
      chk($sformatf("v%0d_tc", i), tc, vecs[i].tc);
      if (!vecs[i].ld && !vecs[i].en) begin
        chk($sformatf("v%0d_j", i), dut.w_j, 0);
        chk($sformatf("v%0d_k", i), dut.w_k, 0);
      end
      @(posedge clk); #1;
      chk($sformatf("v%0d_q", i), q, vecs[i].q);
      chk($sformatf("v%0d_wrap", i), wrap, vecs[i].wr);
      chk($sformatf("v%0d_lerr", i), load_err, vecs[i].le);
      @(negedge clk);
    end
    load = 0; en = 0;

    // Cascade: 25 edges from reset
    rst = 1;
    #1 rst = 0;
    c_en = 1;
    m_lo = 0; m_hi = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (m_lo == 9) begin
        m_lo = 0;
        m_hi = (m_hi + 1) % 10;
      end else begin
        m_lo++;
      end
      chk($sformatf("casc%0d", i), {hi_q, lo_q}, (m_hi << 4) | m_lo);
    end
    chk("casc_final", {hi_q, lo_q}, 8'h25);
    c_en = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jk_sync_counter.md
Name: jk_sync_counter

Overview:
- Synchronous modulo-N up/down counter built from a bank of JK flip-flop cells. It consumes the JK storage element as its state register.
- Next-state logic computes the target count, then converts it to per-bit J/K excitation (J = ~q & nxt, K = q & ~nxt).
- Sits directly downstream of the JK flip-flop stage in the sequential-logic set. It is the first block that composes JK cells into a multi-bit machine.
- Provides load, enable, direction and a cascade carry so several instances can be chained.

Parameters:
- WIDTH, 4, number of JK cells / count bits.
- MODULUS, 10, count range 0..MODULUS-1. Must satisfy 2 <= MODULUS <= 2**WIDTH; elaboration-time check.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load.
- din  input  WIDTH  load value.
- q  output  WIDTH  current count, taken directly from the JK cell outputs.
- tc  output  1  terminal count, combinational. Asserted when en=1 and either (up=1, q=MODULUS-1) or (up=0, q=0). Used as cascade enable.
- wrap  output  1  registered one-cycle pulse the cycle after the counter wraps.
- load_err  output  1  registered one-cycle pulse the cycle after a load with din >= MODULUS.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset: while rst=1, q=0, wrap=0 and load_err=0 immediately, independent of clk. Release is synchronous to the next rising edge; the first count takes effect on the first rising edge with rst=0.
- Priority each rising edge is load > en > hold.
- Load, din < MODULUS: q <= din next edge; wrap=0, load_err=0.
- Load, din >= MODULUS: q <= 0; load_err=1 for exactly one cycle; wrap=0.
- A load overrides en in the same cycle; no count occurs.
- en=1, up=1: q <= q+1. At q=MODULUS-1, q <= 0 and wrap pulses 1.
- en=1, up=0: q <= q-1. At q=0, q <= MODULUS-1 and wrap pulses 1.
- en=0, load=0: hold. The J=K=0 condition is presented to every cell.
- Latency: q reflects a count or load one clock after the qualifying edge. wrap and load_err align with the q update.
- Excitation per bit i: J[i] = ~q[i] & nxt[i], K[i] = q[i] & ~nxt[i]. J=K=1 is never generated by this block.
  - The excitation table must still produce toggle behaviour in the cell.
  - The cell has full JK semantics: 00 hold, 10 set, 01 reset, 11 toggle.
- Out-of-range state (q >= MODULUS) is unreachable from reset or load. If forced, the next en cycle goes to 0 for up and MODULUS-1 for down; wrap is not asserted.
- Direction change mid-count takes effect on the same edge; no pipeline.
- tc depends on the current en, up and q only. It is not registered.
- Arithmetic is done in WIDTH bits. Comparisons against MODULUS-1 use WIDTH-bit constants, so the MODULUS=2**WIDTH case works without overflow.

Decomposition:
- Shared package jk_seq_pkg:
  - JK excitation encoding constants (HOLD=2'b00, RESET=2'b01, SET=2'b10, TOGGLE=2'b11).
  - Function jk_excite(cur, nxt) returning {J,K}.
- Sub-module jk_ff_cell: single rising-edge JK flip-flop.
  - Ports clk, rst (async active-high, q->0), j, k, q.
  - Instantiated WIDTH times in a generate loop.
- All next-state, tc, wrap and load_err logic lives in jk_sync_counter.

Test Plan (WIDTH=4, MODULUS=10):
- Reset: assert rst mid-count at q=7, between clock edges -> q=0 immediately, before the next edge. Release rst, en=1, up=1 -> q=1 after first edge.
- Up-wrap: en=1, up=1 from q=0 for 10 edges -> q sequence 1..9,0. wrap=1 only in the cycle q becomes 0. tc=1 only while q=9.
- Down-wrap: load din=2, then en=1, up=0 -> q sequence 2,1,0,9,8. wrap=1 on the cycle q becomes 9. tc=1 while q=0.
- Load priority and error: load=1, en=1, din=5 -> q=5, no increment. load=1, din=12 -> q=0 and load_err=1 for one cycle.
- Hold: en=0 for 5 cycles at q=6 -> q stays 6; wrap=0, tc=0. Check all J/K excitation inputs to the cells are 00.
- Cascade: two instances, low instance's tc driving the high instance's en, en=1, up=1, 25 edges from reset -> {high,low}=2,5. Check high increments only on low 9->0 transitions.
